data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder.sv | 218 +++++++++++++++++++++
 tb/tb_data_mem_responder.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// data_mem_responder: word-organised data memory behind a valid/ready request
// port and a valid/ready response port. RV32I loads and stores are supported,
// with a fixed number of wait states per access and fault detection.
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o
);

  localparam int unsigned IDX_W   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0]  WAIT_LD = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic        accept;
  logic        enter_resp;
  logic        acc_we;
  logic [2:0]  acc_funct3;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  logic        acc_err;
  logic [IDX_W-1:0] mem_idx;
  logic [31:0] rd_word;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_val;
  logic [3:0]  wr_be;
  logic [31:0] wr_data;
  logic        mem_we;

  assign accept = req_valid_i & req_ready_o;

  // The access completes on the edge entering RESP: straight from IDLE when
  // there are no wait states, otherwise when the wait counter reaches 1.
  assign enter_resp = ((state_q == S_IDLE) && accept && (WAIT_CYCLES == 0)) ||
                      ((state_q == S_WAIT) && (cnt_q <= 4'd1));

  // Select the live request (zero-wait accept) or the latched one.
  always_comb begin
    if (state_q == S_IDLE) begin
      acc_we     = req_we_i;
      acc_funct3 = req_funct3_i;
      acc_addr   = req_addr_i;
      acc_wdata  = req_wdata_i;
    end else begin
      acc_we     = we_q;
      acc_funct3 = funct3_q;
      acc_addr   = addr_q;
      acc_wdata  = wdata_q;
    end
  end

  // Fault detection: misalignment, out-of-range word index, illegal funct3.
  always_comb begin
    acc_err = 1'b0;
    if ({2'b00, acc_addr[31:2]} >= 32'(DEPTH_WORDS)) acc_err = 1'b1;
    if ((acc_funct3[1:0] == 2'b01) && acc_addr[0]) acc_err = 1'b1;
    if ((acc_funct3[1:0] == 2'b10) && (acc_addr[1:0] != 2'b00)) acc_err = 1'b1;
    if (acc_we) begin
      if (acc_funct3 > 3'b010) acc_err = 1'b1;
    end else begin
      if ((acc_funct3 == 3'b011) || (acc_funct3 == 3'b110) || (acc_funct3 == 3'b111)) acc_err = 1'b1;
    end
  end

  assign mem_idx = acc_addr[IDX_W+1:2];
  assign rd_word = mem_q[mem_idx];

  // Lane selection and sign/zero extension of load data.
  always_comb begin
    case (acc_addr[1:0])
      2'd0:    rd_byte = rd_word[7:0];
      2'd1:    rd_byte = rd_word[15:8];
      2'd2:    rd_byte = rd_word[23:16];
      default: rd_byte = rd_word[31:24];
    endcase
    rd_half = acc_addr[1] ? rd_word[31:16] : rd_word[15:0];
    case (acc_funct3)
      3'b000:  load_val = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  load_val = {{16{rd_half[15]}}, rd_half};
      3'b010:  load_val = rd_word;
      3'b100:  load_val = {24'd0, rd_byte};
      3'b101:  load_val = {16'd0, rd_half};
      default: load_val = 32'd0;
    endcase
  end

  // Store byte enables; data is replicated so every enabled lane sees it.
  always_comb begin
    wr_be   = 4'b0000;
    wr_data = acc_wdata;
    case (acc_funct3[1:0])
      2'b00: begin
        wr_be   = 4'b0001 << acc_addr[1:0];
        wr_data = {4{acc_wdata[7:0]}};
      end
      2'b01: begin
        wr_be   = acc_addr[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{acc_wdata[15:0]}};
      end
      2'b10:   wr_be = 4'b1111;
      default: wr_be = 4'b0000;
    endcase
  end

  // A write racing an asserted reset is suppressed so reset always abandons it.
  assign mem_we = enter_resp & acc_we & ~acc_err & reset_i;

  // Storage: byte-lane write, contents are never reset.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) mem_q[mem_idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  // State register and request/response holding registers.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      we_q     <= 1'b0;
      funct3_q <= 3'd0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      rdata_q  <= 32'd0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Next-state logic: accept, count wait states, hold the response.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          we_d     = req_we_i;
          funct3_d = req_funct3_i;
          addr_d   = req_addr_i;
          wdata_d  = req_wdata_i;
          cnt_d    = WAIT_LD;
          state_d  = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (enter_resp) begin
      rdata_d = (acc_err || acc_we) ? 32'd0 : load_val;
      err_d   = acc_err;
    end else if ((state_q == S_RESP) && rsp_ready_i) begin
      rdata_d = 32'd0;
      err_d   = 1'b0;
    end
  end

  // Outputs: ready only in IDLE, response fields zero unless valid.
  always_comb begin
    req_ready_o = (state_q == S_IDLE);
    rsp_valid_o = (state_q == S_RESP);
    rsp_rdata_o = rsp_valid_o ? rdata_q : 32'd0;
    rsp_err_o   = rsp_valid_o ? err_q : 1'b0;
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: the driver pushes expected
// responses, a negedge monitor pops and compares them.
module tb_data_mem_responder;

  localparam int WAIT = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_f3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;

  logic        b_req_valid, b_req_ready, b_req_we;
  logic [2:0]  b_req_f3;
  logic [31:0] b_req_addr, b_req_wdata;
  logic        b_rsp_valid, b_rsp_ready, b_rsp_err;
  logic [31:0] b_rsp_rdata;

  data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(WAIT)) u_dut (
    .clk_i(clk), .reset_i(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_funct3_i(req_f3), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err)
  );

  data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) u_dut0 (
    .clk_i(clk), .reset_i(rst_n),
    .req_valid_i(b_req_valid), .req_ready_o(b_req_ready), .req_we_i(b_req_we),
    .req_funct3_i(b_req_f3), .req_addr_i(b_req_addr), .req_wdata_i(b_req_wdata),
    .rsp_valid_o(b_rsp_valid), .rsp_ready_i(b_rsp_ready),
    .rsp_rdata_o(b_rsp_rdata), .rsp_err_o(b_rsp_err)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;
  int cyc       = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
    string       name;
  } exp_t;
  exp_t exp_q[$];

  function automatic void check(input string name, input logic [31:0] got, input logic [31:0] want);
    total_cnt++;
    if (got === want) pass_cnt++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, want);
  endfunction

  // Monitor: compares each new response, then checks it stays stable.
  exp_t        cur;
  logic        in_resp = 1'b0;
  logic        chk_ready_next = 1'b0;
  logic [31:0] held_rdata;
  logic        held_err;
  always @(negedge clk) begin
    if (!rst_n) begin
      in_resp        = 1'b0;
      chk_ready_next = 1'b0;
    end else begin
      if (chk_ready_next) begin
        check("ready_after_handshake", {31'd0, req_ready}, 32'd1);
        chk_ready_next = 1'b0;
      end
      if (rsp_valid) begin
        if (!in_resp) begin
          if (exp_q.size() == 0) begin
            total_cnt++;
            $display("FAIL unexpected_response: got rdata 0x%08h err %0b, expected no response", rsp_rdata, rsp_err);
          end else begin
            cur = exp_q.pop_front();
            check({cur.name, " latency"}, 32'(cyc - cur.acc), 32'(WAIT));
            check({cur.name, " rdata"}, rsp_rdata, cur.rdata);
            check({cur.name, " err"}, {31'd0, rsp_err}, {31'd0, cur.err});
            $display("rsp %s: rdata 0x%08h err %0b", cur.name, rsp_rdata, rsp_err);
          end
          held_rdata = rsp_rdata;
          held_err   = rsp_err;
          in_resp    = 1'b1;
        end else begin
          check("stall rdata stable", rsp_rdata, held_rdata);
          check("stall err stable", {31'd0, rsp_err}, {31'd0, held_err});
        end
        check("ready low in RESP", {31'd0, req_ready}, 32'd0);
        if (rsp_ready) begin
          in_resp        = 1'b0;
          chk_ready_next = 1'b1;
        end
      end else begin
        check("idle rdata zero", rsp_rdata, 32'd0);
        check("idle err zero", {31'd0, rsp_err}, 32'd0);
      end
    end
  end

  // Issue one request; inputs are scrambled after acceptance to prove latching.
  task automatic do_req(input string name, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err, input bit push);
    int t;
    exp_t e;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_f3    = f3;
    req_addr  = addr;
    req_wdata = wdata;
    t = 0;
    while (!req_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) begin
      total_cnt++;
      $display("FAIL %s accept_timeout: got req_ready 0, expected 1", name);
      req_valid = 1'b0;
      return;
    end
    e.rdata = exp_rdata;
    e.err   = exp_err;
    e.acc   = cyc + 1;
    e.name  = name;
    if (push) exp_q.push_back(e);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we    = ~we;
    req_f3    = 3'b111;
    req_addr  = 32'hFFFF_FFFC;
    req_wdata = 32'h5A5A_5A5A;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || rsp_valid) && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (exp_q.size() != 0 || rsp_valid) begin
      total_cnt++;
      $display("FAIL drain_timeout: got %0d pending, expected 0", exp_q.size());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int acc_n;
    int rsp_n;
    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_f3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
    rsp_ready = 1'b1;
    b_req_valid = 1'b0; b_req_we = 1'b0; b_req_f3 = 3'd0; b_req_addr = 32'd0; b_req_wdata = 32'd0;
    b_rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("reset req_ready", {31'd0, req_ready}, 32'd1);
    check("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("reset rsp_rdata", rsp_rdata, 32'd0);
    check("reset rsp_err", {31'd0, rsp_err}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // name, we, funct3, addr, wdata, expected rdata, expected err
    do_req("SW 0x00",  1'b1, 3'b010, 32'h00, 32'hCAFE_F00D, 32'h0, 1'b0, 1'b1);
    do_req("SW 0x10",  1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b1);
    do_req("LW 0x10",  1'b0, 3'b010, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b1);
    do_req("SB 0x12",  1'b1, 3'b000, 32'h12, 32'hAAAA_AA7F, 32'h0, 1'b0, 1'b1);
    do_req("LW 0x10b", 1'b0, 3'b010, 32'h10, 32'h0, 32'hDE7F_BEEF, 1'b0, 1'b1);
    do_req("LB 0x12",  1'b0, 3'b000, 32'h12, 32'h0, 32'h0000_007F, 1'b0, 1'b1);
    do_req("LBU 0x12", 1'b0, 3'b100, 32'h12, 32'h0, 32'h0000_007F, 1'b0, 1'b1);
    do_req("LH 0x12",  1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFF_DE7F, 1'b0, 1'b1);
    do_req("LHU 0x12", 1'b0, 3'b101, 32'h12, 32'h0, 32'h0000_DE7F, 1'b0, 1'b1);
    do_req("LB 0x13",  1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFF_FFDE, 1'b0, 1'b1);
    do_req("LBU 0x13", 1'b0, 3'b100, 32'h13, 32'h0, 32'h0000_00DE, 1'b0, 1'b1);
    do_req("LB 0x10",  1'b0, 3'b000, 32'h10, 32'h0, 32'hFFFF_FFEF, 1'b0, 1'b1);
    do_req("LH 0x10",  1'b0, 3'b001, 32'h10, 32'h0, 32'hFFFF_BEEF, 1'b0, 1'b1);
    do_req("SW 0x14",  1'b1, 3'b010, 32'h14, 32'h1122_3344, 32'h0, 1'b0, 1'b1);
    do_req("SH 0x16",  1'b1, 3'b001, 32'h16, 32'h5555_8001, 32'h0, 1'b0, 1'b1);
    do_req("LW 0x14",  1'b0, 3'b010, 32'h14, 32'h0, 32'h8001_3344, 1'b0, 1'b1);
    do_req("LH 0x16",  1'b0, 3'b001, 32'h16, 32'h0, 32'hFFFF_8001, 1'b0, 1'b1);
    do_req("SB 0x15",  1'b1, 3'b000, 32'h15, 32'h0000_00C3, 32'h0, 1'b0, 1'b1);
    do_req("LW 0x14b", 1'b0, 3'b010, 32'h14, 32'h0, 32'h8001_C344, 1'b0, 1'b1);
    // faults: no write, rdata 0, err 1
    do_req("LH 0x11 err",  1'b0, 3'b001, 32'h11,  32'h0, 32'h0, 1'b1, 1'b1);
    do_req("SW 0x400 err", 1'b1, 3'b010, 32'h400, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b1);
    do_req("SW 0x02 err",  1'b1, 3'b010, 32'h02,  32'hFFFF_FFFF, 32'h0, 1'b1, 1'b1);
    do_req("SH 0x01 err",  1'b1, 3'b001, 32'h01,  32'hFFFF_FFFF, 32'h0, 1'b1, 1'b1);
    do_req("S f3=100 err", 1'b1, 3'b100, 32'h00,  32'hFFFF_FFFF, 32'h0, 1'b1, 1'b1);
    do_req("L f3=011 err", 1'b0, 3'b011, 32'h00,  32'h0, 32'h0, 1'b1, 1'b1);
    do_req("L f3=110 err", 1'b0, 3'b110, 32'h00,  32'h0, 32'h0, 1'b1, 1'b1);
    do_req("L f3=111 err", 1'b0, 3'b111, 32'h00,  32'h0, 32'h0, 1'b1, 1'b1);
    do_req("LW 0x400 err", 1'b0, 3'b010, 32'h400, 32'h0, 32'h0, 1'b1, 1'b1);
    do_req("LW 0x00",      1'b0, 3'b010, 32'h00,  32'h0, 32'hCAFE_F00D, 1'b0, 1'b1);
    do_req("SW 0x3FC",     1'b1, 3'b010, 32'h3FC, 32'h0BAD_CAFE, 32'h0, 1'b0, 1'b1);
    do_req("LW 0x3FC",     1'b0, 3'b010, 32'h3FC, 32'h0, 32'h0BAD_CAFE, 1'b0, 1'b1);
    wait_drain();

    // Response stall: hold rsp_ready low for 5 cycles once valid appears.
    rsp_ready = 1'b0;
    do_req("LW stall", 1'b0, 3'b010, 32'h10, 32'h0, 32'hDE7F_BEEF, 1'b0, 1'b1);
    t = 0;
    while (!rsp_valid && t < 20) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("stall rsp_valid seen", {31'd0, rsp_valid}, 32'd1);
    repeat (5) @(posedge clk);
    #1 rsp_ready = 1'b1;
    wait_drain();

    // Reset during WAIT abandons the store.
    do_req("SW 0x20",  1'b1, 3'b010, 32'h20, 32'hAAAA_5555, 32'h0, 1'b0, 1'b1);
    do_req("LW 0x20",  1'b0, 3'b010, 32'h20, 32'h0, 32'hAAAA_5555, 1'b0, 1'b1);
    wait_drain();
    do_req("SW 0x20 reset", 1'b1, 3'b010, 32'h20, 32'h1234_5678, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("inreset rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("inreset req_ready", {31'd0, req_ready}, 32'd1);
    check("inreset rsp_rdata", rsp_rdata, 32'd0);
    check("inreset rsp_err", {31'd0, rsp_err}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    do_req("LW 0x20 after reset", 1'b0, 3'b010, 32'h20, 32'h0, 32'hAAAA_5555, 1'b0, 1'b1);
    wait_drain();

    // Zero wait states, back-to-back requests: one access per 2 cycles.
    @(posedge clk);
    #1;
    b_req_valid = 1'b1; b_req_we = 1'b1; b_req_f3 = 3'b010;
    b_req_addr = 32'h8; b_req_wdata = 32'h1357_9BDF;
    acc_n = 0;
    rsp_n = 0;
    repeat (8) begin
      @(negedge clk);
      if (b_req_valid && b_req_ready) acc_n++;
      if (b_rsp_valid && b_rsp_ready) rsp_n++;
    end
    check("b2b accepts in 8 cycles", 32'(acc_n), 32'd4);
    check("b2b responses in 8 cycles", 32'(rsp_n), 32'd4);
    $display("b2b: %0d accepts, %0d responses in 8 cycles", acc_n, rsp_n);
    @(posedge clk);
    #1 b_req_we = 1'b0;
    @(negedge clk);
    check("w0 LW ready", {31'd0, b_req_ready}, 32'd1);
    @(posedge clk);
    #1 b_req_valid = 1'b0;
    @(negedge clk);
    check("w0 LW rsp_valid", {31'd0, b_rsp_valid}, 32'd1);
    check("w0 LW rdata", b_rsp_rdata, 32'h1357_9BDF);
    check("w0 LW err", {31'd0, b_rsp_err}, 32'd0);
    $display("w0 LW 0x08: rdata 0x%08h err %0b", b_rsp_rdata, b_rsp_err);
    repeat (2) @(posedge clk);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
